// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit: fetch, decode and sequencing of the
// datapath for an RV32I subset, with stall and sticky illegal flag.
module unidade_controle_multiciclo #(
  parameter int MEM_WAIT = 1,
  parameter int OPW      = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [6:0]     OPCODE,
  input  logic [2:0]     FUNCT3,
  input  logic           FUNCT7B5,
  input  logic           ZERO,
  input  logic           STALL,
  output logic           reset_wire,
  output logic [OPW-1:0] operacao,
  output logic           WRITE_PC,
  output logic           PC_SRC,
  output logic           WRITE_INSTRUCTION,
  output logic           WR_MEM_INSTR,
  output logic           WR_MEM_DATA,
  output logic           WRITE_REG,
  output logic [1:0]     ALU_SRC_B,
  output logic           MEM_TO_REG,
  output logic [3:0]     ESTADO,
  output logic           ILLEGAL
);

  typedef enum logic [3:0] {
    ST_RESET        = 4'd0,
    ST_BUSCA        = 4'd1,
    ST_SOMA         = 4'd2,
    ST_DECODE       = 4'd3,
    ST_EXEC         = 4'd4,
    ST_ENDERECO     = 4'd5,
    ST_MEM_LE       = 4'd6,
    ST_ESCRITA_LOAD = 4'd7,
    ST_MEM_ESC      = 4'd8,
    ST_DESVIO       = 4'd9,
    ST_ERRO         = 4'd15
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MEM_WAIT - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] alu_op, op3;
  logic       is_r, is_i, is_lui;
  logic       is_ld, is_st, is_br;
  logic       alu_ok, br_ok, taken;
  logic       hold, gate;

  assign is_r   = OPCODE == 7'b0110011;
  assign is_i   = OPCODE == 7'b0010011;
  assign is_lui = OPCODE == 7'b0110111;
  assign is_ld  = OPCODE == 7'b0000011;
  assign is_st  = OPCODE == 7'b0100011;
  assign is_br  = OPCODE == 7'b1100011;

  assign br_ok = FUNCT3[2:1] == 2'b00;
  assign taken = FUNCT3[0] ? !ZERO : ZERO;

  // ERRO is a dead end, so a stall there is meaningless
  assign hold = STALL && state != ST_ERRO;
  // write strobes stay live while RST is low so reset outputs win
  assign gate = hold && RST;

  always_comb begin
    alu_op = 3'd0;
    alu_ok = 1'b1;
    case (FUNCT3)
      3'b000:  alu_op = (is_r && FUNCT7B5) ? 3'd2 : 3'd1;
      3'b111:  alu_op = 3'd3;
      3'b110:  alu_op = 3'd4;
      3'b100:  alu_op = 3'd5;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = 4'd0;
    if (hold) begin
      cnt_n = cnt;
    end else begin
      case (state)
        ST_RESET: state_n = ST_BUSCA;
        ST_BUSCA:
          if (cnt == CNT_LAST) state_n = ST_SOMA;
          else cnt_n = cnt + 4'd1;
        ST_SOMA: state_n = ST_DECODE;
        ST_DECODE:
          if (((is_r || is_i) && alu_ok) || is_lui)
            state_n = ST_EXEC;
          else if (is_ld || is_st)
            state_n = ST_ENDERECO;
          else if (is_br && br_ok)
            state_n = ST_DESVIO;
          else
            state_n = ST_ERRO;
        ST_EXEC: state_n = ST_BUSCA;
        ST_ENDERECO:
          state_n = is_ld ? ST_MEM_LE : ST_MEM_ESC;
        ST_MEM_LE:
          if (cnt == CNT_LAST) state_n = ST_ESCRITA_LOAD;
          else cnt_n = cnt + 4'd1;
        ST_ESCRITA_LOAD: state_n = ST_BUSCA;
        ST_MEM_ESC:      state_n = ST_BUSCA;
        ST_DESVIO:       state_n = ST_BUSCA;
        default:         state_n = ST_ERRO;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_RESET;
      cnt     <= 4'd0;
      ILLEGAL <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state_n == ST_ERRO) ILLEGAL <= 1'b1;
    end
  end

  always_comb begin
    reset_wire        = 1'b0;
    op3               = 3'd0;
    WRITE_PC          = 1'b0;
    PC_SRC            = 1'b0;
    WRITE_INSTRUCTION = 1'b0;
    WR_MEM_INSTR      = 1'b0;
    WR_MEM_DATA       = 1'b0;
    WRITE_REG         = 1'b0;
    ALU_SRC_B         = 2'd0;
    MEM_TO_REG        = 1'b0;
    case (state)
      ST_RESET: reset_wire = 1'b1;
      ST_BUSCA: WR_MEM_INSTR = 1'b1;
      ST_SOMA: begin
        WRITE_PC          = 1'b1;
        WRITE_INSTRUCTION = 1'b1;
        op3               = 3'd1;
        ALU_SRC_B         = 2'd1;
      end
      ST_EXEC: begin
        WRITE_REG = 1'b1;
        ALU_SRC_B = is_r ? 2'd0 : 2'd2;
        op3       = is_lui ? 3'd0 : alu_op;
      end
      ST_ENDERECO: begin
        op3       = 3'd1;
        ALU_SRC_B = 2'd2;
      end
      ST_ESCRITA_LOAD: begin
        WRITE_REG  = 1'b1;
        MEM_TO_REG = 1'b1;
      end
      ST_MEM_ESC: WR_MEM_DATA = 1'b1;
      ST_DESVIO: begin
        op3      = 3'd2;
        WRITE_PC = br_ok && taken;
        PC_SRC   = br_ok && taken;
      end
      default: ;
    endcase
    if (gate) begin
      reset_wire        = 1'b0;
      WRITE_PC          = 1'b0;
      WRITE_INSTRUCTION = 1'b0;
      WRITE_REG         = 1'b0;
      WR_MEM_DATA       = 1'b0;
    end
  end

  assign operacao = OPW'(op3);
  assign ESTADO   = state;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Random instruction stream against a per-instruction expected
// cycle trace, with random stalls and asynchronous reset pulses.
module tb_unidade_controle_multiciclo;
  localparam int MW  = 3;
  localparam int OPW = 4;
  localparam int LIMIT = 60000;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [6:0]     OPCODE = '0;
  logic [2:0]     FUNCT3 = '0;
  logic           FUNCT7B5 = 1'b0;
  logic           ZERO = 1'b0;
  logic           STALL = 1'b0;
  logic           reset_wire;
  logic [OPW-1:0] operacao;
  logic           WRITE_PC, PC_SRC;
  logic           WRITE_INSTRUCTION, WR_MEM_INSTR;
  logic           WR_MEM_DATA, WRITE_REG;
  logic [1:0]     ALU_SRC_B;
  logic           MEM_TO_REG;
  logic [3:0]     ESTADO;
  logic           ILLEGAL;

  always #5 CLK = ~CLK;

  unidade_controle_multiciclo #(
    .MEM_WAIT(MW),
    .OPW(OPW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .OPCODE(OPCODE),
    .FUNCT3(FUNCT3),
    .FUNCT7B5(FUNCT7B5),
    .ZERO(ZERO),
    .STALL(STALL),
    .reset_wire(reset_wire),
    .operacao(operacao),
    .WRITE_PC(WRITE_PC),
    .PC_SRC(PC_SRC),
    .WRITE_INSTRUCTION(WRITE_INSTRUCTION),
    .WR_MEM_INSTR(WR_MEM_INSTR),
    .WR_MEM_DATA(WR_MEM_DATA),
    .WRITE_REG(WRITE_REG),
    .ALU_SRC_B(ALU_SRC_B),
    .MEM_TO_REG(MEM_TO_REG),
    .ESTADO(ESTADO),
    .ILLEGAL(ILLEGAL)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] op;
    logic       wpc, pcs, wi, wmi, wmd, wr;
    logic [1:0] asb;
    logic       m2r, rw, ill;
  } exp_t;

  logic [18:0] obs;
  assign obs = {ESTADO, operacao, WRITE_PC, PC_SRC,
                WRITE_INSTRUCTION, WR_MEM_INSTR,
                WR_MEM_DATA, WRITE_REG, ALU_SRC_B,
                MEM_TO_REG, reset_wire, ILLEGAL};

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int s);
    exp_t e = '0;
    e.st = 4'(s);
    return e;
  endfunction

  function automatic exp_t stalled(input exp_t e);
    exp_t r = e;
    r.wpc = 1'b0;
    r.wi  = 1'b0;
    r.wr  = 1'b0;
    r.wmd = 1'b0;
    r.rw  = 1'b0;
    return r;
  endfunction

  // Expected cycle-by-cycle trace of one instruction from fetch on
  task automatic build(input logic [6:0] opc, input logic [2:0] f3,
                       input logic f7, input logic z);
    exp_t e;
    int   code;
    for (int k = 0; k < MW; k++) begin
      e = mk(1); e.wmi = 1'b1; q.push_back(e);
    end
    e = mk(2); e.wpc = 1'b1; e.wi = 1'b1;
    e.op = 4'd1; e.asb = 2'd1; q.push_back(e);
    q.push_back(mk(3));
    code = -1;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      if (f3 == 3'd0) code = (opc == 7'b0110011 && f7) ? 2 : 1;
      else if (f3 == 3'd7) code = 3;
      else if (f3 == 3'd6) code = 4;
      else if (f3 == 3'd4) code = 5;
      if (code >= 0) begin
        e = mk(4); e.wr = 1'b1; e.op = 4'(code);
        e.asb = (opc == 7'b0110011) ? 2'd0 : 2'd2;
        q.push_back(e);
        return;
      end
    end else if (opc == 7'b0110111) begin
      e = mk(4); e.wr = 1'b1; e.asb = 2'd2;
      q.push_back(e);
      return;
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      e = mk(5); e.op = 4'd1; e.asb = 2'd2; q.push_back(e);
      if (opc == 7'b0000011) begin
        for (int k = 0; k < MW; k++) q.push_back(mk(6));
        e = mk(7); e.wr = 1'b1; e.m2r = 1'b1; q.push_back(e);
      end else begin
        e = mk(8); e.wmd = 1'b1; q.push_back(e);
      end
      return;
    end else if (opc == 7'b1100011 && f3 < 3'd2) begin
      e = mk(9); e.op = 4'd2;
      e.wpc = (f3 == 3'd0) ? z : !z;
      e.pcs = e.wpc;
      q.push_back(e);
      return;
    end
    e = mk(15); e.ill = 1'b1; q.push_back(e);
  endtask

  // Entered just after a negedge; returns just after a later one
  task automatic do_reset();
    exp_t e;
    RST   = 1'b0;
    STALL = 1'($urandom_range(0, 1));
    #2;
    e = mk(0); e.rw = 1'b1;
    chk("reset_async", 32'(obs), 32'(e));
    @(negedge CLK);
    chk("reset_held", 32'(obs), 32'(e));
    RST = 1'b1;
    q.delete();
    q.push_back(e);
  endtask

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7, z;
  logic [2:0] good [4] = '{3'd0, 3'd7, 3'd6, 3'd4};
  exp_t       cur;
  int         cyc = 0;
  int         erro_cyc;
  int         sel;
  bit         abort = 1'b0;

  initial begin
    do_reset();
    for (int n = 0; n < 400 && !abort; n++) begin
      sel = int'($urandom_range(0, 9));
      f3  = 3'($urandom_range(0, 7));
      f7  = 1'($urandom_range(0, 1));
      z   = 1'($urandom_range(0, 1));
      case (sel)
        0, 1: opc = 7'b0110011;
        2:    opc = 7'b0010011;
        3:    opc = 7'b0110111;
        4:    opc = 7'b0000011;
        5:    opc = 7'b0100011;
        6, 7: opc = 7'b1100011;
        8:    opc = 7'($urandom_range(0, 127));
        default: opc = 7'b1110011;
      endcase
      if (sel <= 2 && $urandom_range(0, 3) != 0)
        f3 = good[$urandom_range(0, 3)];
      if (sel == 6 || sel == 7)
        if ($urandom_range(0, 7) != 0)
          f3 = 3'($urandom_range(0, 1));
      OPCODE   = opc;
      FUNCT3   = f3;
      FUNCT7B5 = f7;
      ZERO     = z;
      build(opc, f3, f7, z);
      erro_cyc = 0;
      while (q.size() > 0) begin
        if ($urandom_range(0, 149) == 0) begin
          do_reset();
          build(opc, f3, f7, z);
        end
        STALL = ($urandom_range(0, 4) == 0);
        #1;
        cur = STALL ? stalled(q[0]) : q[0];
        chk($sformatf("state%0d", q[0].st), 32'(obs), 32'(cur));
        cyc++;
        if (cyc > LIMIT) begin
          chk("cycle_budget", 32'(cyc), 32'(LIMIT));
          abort = 1'b1;
          break;
        end
        if (q[0].st == 4'd15) begin
          erro_cyc++;
          if (erro_cyc >= 22) begin
            @(negedge CLK);
            do_reset();
            break;
          end
        end else if (!STALL) begin
          void'(q.pop_front());
        end
        @(negedge CLK);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
